// File: rtl/vga_text_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : vga_text_pkg                                                    |
// | Brief    : 640x480 timing defaults, text grid geometry, address packing.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package vga_text_pkg;

    localparam int unsigned COLS    = 80;
    localparam int unsigned ROWS    = 30;
    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;

    localparam int unsigned H_VIS   = COLS * GLYPH_W;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS   = ROWS * GLYPH_H;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Char RAM address layout is {3'b0, lin[4:0], col[7:0]}; col never exceeds 79.
    function automatic logic [15:0] pack_char_addr(input logic [4:0] lin, input logic [6:0] col);
        return {3'b000, lin, 1'b0, col};
    endfunction

    function automatic logic [11:0] pack_font_addr(input logic [7:0] code, input logic [3:0] row);
        return {code, row};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_text_timing.sv
// +----------------------------------------------------------------------------+
// | Module   : vga_text_timing                                                 |
// | Brief    : VGA h/v counters, raw sync/DE and text cell/glyph indices.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_text_timing
    import vga_text_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [6:0] o_col,
    output logic [4:0] o_lin,
    output logic [3:0] o_glyph_row,
    output logic [2:0] o_bit_idx,
    output logic       o_hsync_raw,
    output logic       o_vsync_raw,
    output logic       o_de_raw,
    output logic       o_origin,
    output logic       o_frame_end
);

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       w_line_end;

    assign w_line_end = (r_hcnt == 10'(H_TOTAL - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_line_end) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == 10'(V_TOTAL - 1)) ? '0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 10'd1;
        end
    end

    assign o_col       = r_hcnt[9:3];
    assign o_lin       = r_vcnt[8:4];
    assign o_glyph_row = r_vcnt[3:0];
    assign o_bit_idx   = r_hcnt[2:0];

    assign o_hsync_raw = !((r_hcnt >= 10'(H_VIS + H_FP)) && (r_hcnt <= 10'(H_VIS + H_FP + H_SYNC - 1)));
    assign o_vsync_raw = !((r_vcnt >= 10'(V_VIS + V_FP)) && (r_vcnt <= 10'(V_VIS + V_FP + V_SYNC - 1)));
    assign o_de_raw    = (r_hcnt < 10'(H_VIS)) && (r_vcnt < 10'(V_VIS));
    assign o_origin    = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
    assign o_frame_end = w_line_end && (r_vcnt == 10'(V_TOTAL - 1));

endmodule

`default_nettype wire

// File: rtl/vga_text_scanout.sv
// +----------------------------------------------------------------------------+
// | Module   : vga_text_scanout                                                |
// | Brief    : 80x30 text-mode VGA scanout, 3-stage char RAM / font ROM pipe.  |
// |            Optional blinking cursor when VGA_TEXT_CURSOR_EN is defined.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_text_scanout
    import vga_text_pkg::*;
#(
    parameter logic [11:0] FG_RGB       = 12'hFFF,
    parameter logic [11:0] BG_RGB       = 12'h000,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_char_addr,
    input  logic [8:0]  i_char_data,
    output logic [11:0] o_font_addr,
    input  logic [7:0]  i_font_data,
    input  logic [4:0]  i_cursor_lin,
    input  logic [6:0]  i_cursor_col,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [11:0] o_rgb,
    output logic        o_frame_start
);

    logic [6:0] w_col;
    logic [4:0] w_lin;
    logic [3:0] w_row;
    logic [2:0] w_bit;
    logic       w_hs, w_vs, w_de, w_origin, w_frame_end;

    vga_text_timing u_timing (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .o_col       (w_col),
        .o_lin       (w_lin),
        .o_glyph_row (w_row),
        .o_bit_idx   (w_bit),
        .o_hsync_raw (w_hs),
        .o_vsync_raw (w_vs),
        .o_de_raw    (w_de),
        .o_origin    (w_origin),
        .o_frame_end (w_frame_end)
    );

    logic [3:0] r_row_d1;
    logic [2:0] r_bit_d1, r_bit_d2;
    logic       r_hs_d1, r_hs_d2, r_vs_d1, r_vs_d2;
    logic       r_de_d1, r_de_d2, r_org_d1, r_org_d2;
    logic       r_inv_d2;
    logic       w_cursor;
    logic       w_pix;

    // S0: char address from the counters, side-band enters the delay line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_char_addr <= '0;
            r_row_d1    <= '0;
            r_bit_d1    <= '0;
            r_hs_d1     <= 1'b1;
            r_vs_d1     <= 1'b1;
            r_de_d1     <= 1'b0;
            r_org_d1    <= 1'b0;
        end else begin
            if (w_de) begin
                o_char_addr <= pack_char_addr(w_lin, w_col);
            end
            r_row_d1 <= w_row;
            r_bit_d1 <= w_bit;
            r_hs_d1  <= w_hs;
            r_vs_d1  <= w_vs;
            r_de_d1  <= w_de;
            r_org_d1 <= w_origin;
        end
    end

    // S1: font address from the char code.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_font_addr <= '0;
            r_inv_d2    <= 1'b0;
            r_bit_d2    <= '0;
            r_hs_d2     <= 1'b1;
            r_vs_d2     <= 1'b1;
            r_de_d2     <= 1'b0;
            r_org_d2    <= 1'b0;
        end else begin
            if (r_de_d1) begin
                o_font_addr <= pack_font_addr(i_char_data[7:0], r_row_d1);
            end
            r_inv_d2 <= i_char_data[8];
            r_bit_d2 <= r_bit_d1;
            r_hs_d2  <= r_hs_d1;
            r_vs_d2  <= r_vs_d1;
            r_de_d2  <= r_de_d1;
            r_org_d2 <= r_org_d1;
        end
    end

`ifdef VGA_TEXT_CURSOR_EN
    localparam int unsigned c_BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_on;
    logic                 r_cur_d1, r_cur_d2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_cur_d1    <= 1'b0;
            r_cur_d2    <= 1'b0;
        end else begin
            if (w_frame_end) begin
                if (r_blink_cnt == c_BLINK_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= !r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
            // Underline cursor covers the bottom two glyph rows of its cell.
            r_cur_d1 <= r_blink_on && (w_lin == i_cursor_lin) && (w_col == i_cursor_col)
                        && (w_row[3:1] == 3'b111);
            r_cur_d2 <= r_cur_d1;
        end
    end

    assign w_cursor = r_cur_d2;
`else
    logic w_unused_cursor;

    assign w_unused_cursor = ^{i_cursor_lin, i_cursor_col, w_frame_end};
    assign w_cursor        = 1'b0;
`endif

    assign w_pix = i_font_data[3'd7 - r_bit_d2] ^ r_inv_d2 ^ w_cursor;

    // S2: pixel colour and aligned sync/DE outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rgb         <= '0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_rgb         <= r_de_d2 ? (w_pix ? FG_RGB : BG_RGB) : 12'h000;
            o_hsync       <= r_hs_d2;
            o_vsync       <= r_vs_d2;
            o_de          <= r_de_d2;
            o_frame_start <= r_org_d2;
        end
    end

endmodule

`default_nettype wire
